// File: rtl/rv64g_l2_pkg.sv
// rtl/rv64g_l2_pkg.sv - shared L2 coherence constants and types
// Purpose: TileLink opcode/cap encodings and the probe-scheduler state enum.
// Ports: none (package).
package rv64g_l2_pkg;

  localparam logic [2:0] TL_PROBE          = 3'd6;
  localparam logic [2:0] TL_PROBE_ACK      = 3'd4;
  localparam logic [2:0] TL_PROBE_ACK_DATA = 3'd5;

  localparam logic [1:0] CAP_TO_T = 2'd0;
  localparam logic [1:0] CAP_TO_B = 2'd1;
  localparam logic [1:0] CAP_TO_N = 2'd2;

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_SEND = 2'd1,
    PS_WAIT = 2'd2,
    PS_DONE = 2'd3
  } probe_state_e;

endpackage

// File: rtl/rv64g_l2_lowbit_enc.sv
// rtl/rv64g_l2_lowbit_enc.sv - lowest-set-bit priority encoder
// Purpose: returns the index of the lowest set bit of a vector and an any-bit flag.
// Ports:
//   i_vec  in  WIDTH  vector to scan
//   o_idx  out IDX_W  index of lowest set bit (0 when vector is empty)
//   o_any  out 1      vector has at least one bit set
module rv64g_l2_lowbit_enc #(
  parameter int WIDTH = 4,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rv64g_l2_probe_sched.sv
// rtl/rv64g_l2_probe_sched.sv - L2 probe scheduler: issues B-channel probes and tracks acks
// Purpose: serialises one Probe per targeted core and waits for every ProbeAck(Data).
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   start_valid_i/ready_o/addr/mask/param  round request from the L2 FSM
//   b_opcode_o/param_o/address_o/dest_o/valid_o, b_ready_i  TileLink B channel
//   ack_valid_i/ack_id_i/ack_data_i   decoded ProbeAck/ProbeAckData from C channel
//   busy_o, pending_o, done_o, dirty_o, err_o  status toward the FSM
module rv64g_l2_probe_sched
  import rv64g_l2_pkg::*;
#(
  parameter int CORES  = 4,
  parameter int ADDR_W = 64,
  parameter int CID_W  = $clog2(CORES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [CORES-1:0]  start_mask_i,
  input  logic [1:0]        start_param_i,
  output logic [2:0]        b_opcode_o,
  output logic [1:0]        b_param_o,
  output logic [ADDR_W-1:0] b_address_o,
  output logic [CID_W-1:0]  b_dest_o,
  output logic              b_valid_o,
  input  logic              b_ready_i,
  input  logic              ack_valid_i,
  input  logic [CID_W-1:0]  ack_id_i,
  input  logic              ack_data_i,
  output logic              busy_o,
  output logic [CORES-1:0]  pending_o,
  output logic              done_o,
  output logic              dirty_o,
  output logic              err_o
);

  localparam logic [CORES-1:0]  ONE_HOT0  = CORES'(1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-6){1'b1}}, 6'b0};

  probe_state_e      r_state;
  probe_state_e      w_state_nxt;
  logic [CORES-1:0]  r_to_send;
  logic [CORES-1:0]  r_pending;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_param;
  logic              r_dirty;
  logic              r_err;

  logic [CID_W-1:0]  w_low_idx;
  logic              w_low_any;
  logic              w_accept;
  logic              w_hs;
  logic              w_ack_hit;
  logic              w_ack_err;
  logic [CORES-1:0]  w_hs_set;
  logic [CORES-1:0]  w_ack_clr;
  logic [CORES-1:0]  w_to_send_nxt;
  logic [CORES-1:0]  w_pending_nxt;

  rv64g_l2_lowbit_enc #(
    .WIDTH (CORES),
    .IDX_W (CID_W)
  ) u_lowbit (
    .i_vec (r_to_send),
    .o_idx (w_low_idx),
    .o_any (w_low_any)
  );

  assign w_accept = start_valid_i && (r_state == PS_IDLE);
  assign w_hs     = b_valid_o && b_ready_i;

  // The ack is judged against the pending set as it stood before this
  // cycle's handshake, so a same-core ack+handshake is an error.
  assign w_ack_hit = ack_valid_i && (r_state != PS_IDLE) && (int'(ack_id_i) < CORES)
                     && r_pending[ack_id_i];
  assign w_ack_err = ack_valid_i && !w_ack_hit;

  assign w_hs_set      = w_hs      ? (ONE_HOT0 << w_low_idx) : '0;
  assign w_ack_clr     = w_ack_hit ? (ONE_HOT0 << ack_id_i)  : '0;
  assign w_to_send_nxt = r_to_send & ~w_hs_set;
  assign w_pending_nxt = (r_pending & ~w_ack_clr) | w_hs_set;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PS_IDLE: begin
        if (start_valid_i) w_state_nxt = (start_mask_i == '0) ? PS_DONE : PS_SEND;
      end
      PS_SEND: begin
        if (w_to_send_nxt == '0) w_state_nxt = (w_pending_nxt == '0) ? PS_DONE : PS_WAIT;
      end
      PS_WAIT: begin
        if (w_pending_nxt == '0) w_state_nxt = PS_DONE;
      end
      PS_DONE: w_state_nxt = PS_IDLE;
      default: w_state_nxt = PS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= PS_IDLE;
      r_to_send <= '0;
      r_pending <= '0;
      r_addr    <= '0;
      r_param   <= '0;
      r_dirty   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_ack_err;
      if (w_accept) begin
        r_addr    <= start_addr_i & LINE_MASK;
        r_param   <= (start_param_i == 2'd3) ? CAP_TO_N : start_param_i;
        r_to_send <= start_mask_i;
        r_pending <= '0;
        r_dirty   <= 1'b0;
      end else if (r_state != PS_IDLE) begin
        r_to_send <= w_to_send_nxt;
        r_pending <= w_pending_nxt;
        if (w_ack_hit && ack_data_i) r_dirty <= 1'b1;
      end
    end
  end

  assign start_ready_o = (r_state == PS_IDLE);
  assign busy_o        = (r_state != PS_IDLE);
  assign b_valid_o     = (r_state == PS_SEND) && w_low_any;
  assign b_dest_o      = w_low_idx;
  assign b_opcode_o    = TL_PROBE;
  assign b_param_o     = r_param;
  assign b_address_o   = r_addr;
  assign pending_o     = r_pending;
  assign done_o        = (r_state == PS_DONE);
  assign dirty_o       = done_o && r_dirty;
  assign err_o         = r_err;

endmodule

// File: tb/tb_rv64g_l2_probe_sched.sv
// tb/tb_rv64g_l2_probe_sched.sv - self-checking bench for rv64g_l2_probe_sched
module tb_rv64g_l2_probe_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [63:0] start_addr = '0;
  logic [3:0]  start_mask = '0;
  logic [1:0]  start_param = '0;
  logic [2:0]  b_opcode;
  logic [1:0]  b_param;
  logic [63:0] b_address;
  logic [1:0]  b_dest;
  logic        b_valid;
  logic        b_ready = 1'b1;
  logic        ack_valid = 1'b0;
  logic [1:0]  ack_id = '0;
  logic        ack_data = 1'b0;
  logic        busy;
  logic [3:0]  pending;
  logic        done;
  logic        dirty;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv64g_l2_probe_sched dut (
    .clk_i(clk), .rst_i(rst),
    .start_valid_i(start_valid), .start_ready_o(start_ready),
    .start_addr_i(start_addr), .start_mask_i(start_mask), .start_param_i(start_param),
    .b_opcode_o(b_opcode), .b_param_o(b_param), .b_address_o(b_address),
    .b_dest_o(b_dest), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ack_valid_i(ack_valid), .ack_id_i(ack_id), .ack_data_i(ack_data),
    .busy_o(busy), .pending_o(pending), .done_o(done), .dirty_o(dirty), .err_o(err)
  );

  // Reference model: a round is a queue of cores still to probe (ascending),
  // a set of outstanding probes, and a dirty flag; done/err are pulses.
  bit          m_active;
  bit          m_done;
  bit          m_err;
  bit          m_dirty;
  int          m_q[$];
  logic [3:0]  m_pend;
  logic [63:0] m_addr;
  logic [1:0]  m_param;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_err = 0; m_dirty = 0;
    m_q.delete(); m_pend = '0; m_addr = '0; m_param = '0;
  endtask

  task automatic check_outputs();
    bit exp_busy;
    bit exp_valid;
    exp_busy  = m_active || m_done;
    exp_valid = m_active && (m_q.size() > 0);
    chk("start_ready", start_ready, !exp_busy);
    chk("busy", busy, exp_busy);
    chk("b_valid", b_valid, exp_valid);
    chk("b_opcode", b_opcode, 3'd6);
    chk("pending", pending, m_pend);
    chk("done", done, m_done);
    chk("dirty", dirty, m_done && m_dirty);
    chk("err", err, m_err);
    if (exp_valid) begin
      chk("b_dest", b_dest, m_q[0]);
      chk("b_address", b_address, m_addr);
      chk("b_param", b_param, m_param);
    end
  endtask

  // One clock: check at negedge, predict from the inputs, advance after posedge.
  task automatic step();
    bit         n_active, n_done, n_err, n_dirty;
    int         n_q[$];
    logic [3:0] n_pend;
    logic [63:0] n_addr;
    logic [1:0] n_param;
    @(negedge clk);
    check_outputs();
    n_active = m_active; n_done = 0; n_err = 0; n_dirty = m_dirty;
    n_q = m_q; n_pend = m_pend; n_addr = m_addr; n_param = m_param;
    if (!m_active) begin
      if (ack_valid) n_err = 1;
      if (!m_done && start_valid) begin
        n_addr  = {start_addr[63:6], 6'b0};
        n_param = (start_param == 2'd3) ? 2'd2 : start_param;
        n_q.delete();
        for (int c = 0; c < 4; c++) if (start_mask[c]) n_q.push_back(c);
        n_pend = '0; n_dirty = 0;
        if (n_q.size() == 0) n_done = 1;
        else n_active = 1;
      end
    end else begin
      if (ack_valid) begin
        if (m_pend[ack_id]) begin
          n_pend[ack_id] = 1'b0;
          n_dirty = n_dirty | ack_data;
        end else begin
          n_err = 1;
        end
      end
      if (n_q.size() > 0 && b_ready) begin
        n_pend[n_q[0]] = 1'b1;
        void'(n_q.pop_front());
      end
      if (n_q.size() == 0 && n_pend == '0) begin
        n_active = 0; n_done = 1;
      end
    end
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else begin
      m_active = n_active; m_done = n_done; m_err = n_err; m_dirty = n_dirty;
      m_q = n_q; m_pend = n_pend; m_addr = n_addr; m_param = n_param;
    end
  endtask

  task automatic quiet();
    start_valid = 0; ack_valid = 0; ack_data = 0; b_ready = 1;
  endtask

  task automatic start(input logic [3:0] mask, input logic [1:0] param);
    start_valid = 1; start_mask = mask; start_param = param;
    start_addr = {$urandom, $urandom};
    step();
    start_valid = 0;
  endtask

  task automatic ack(input int id, input bit data);
    ack_valid = 1; ack_id = 2'(id); ack_data = data;
    step();
    ack_valid = 0; ack_data = 0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((m_active || m_done) && n < budget) begin step(); n++; end
    if (m_active || m_done) chk("drain_timeout", 1, 0);
    step();
  endtask

  initial begin
    model_reset();
    quiet();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_b_address", b_address, 64'd0);
    chk("reset_b_param", b_param, 2'd0);
    chk("reset_b_dest", b_dest, 2'd0);
    rst = 0;
    step();

    // 1011, cap toN, acks 3,0,1
    start(4'b1011, 2'd2);
    step(); step(); step();
    ack(3, 0); ack(0, 0); ack(1, 0);
    drain(10);

    // 0100 with B stalled for 5 cycles, dirty ack
    b_ready = 0;
    start(4'b0100, 2'd1);
    repeat (5) step();
    b_ready = 1;
    step();
    ack(2, 1);
    drain(10);

    // empty mask
    start(4'b0000, 2'd0);
    drain(10);

    // premature and untargeted acks
    b_ready = 0;
    start(4'b0011, 2'd3);
    ack(1, 0);
    ack(3, 1);
    b_ready = 1;
    step(); step();
    ack(0, 0); ack(1, 0);
    drain(10);

    // ack for core 0 alongside core 1's handshake
    start(4'b0011, 2'd0);
    step();
    ack(0, 1);
    ack(1, 0);
    drain(10);

    // async reset in WAIT with two probes outstanding
    start(4'b0110, 2'd1);
    step(); step();
    chk("pre_reset_pending", pending, 4'b0110);
    rst = 1;
    #1;
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pending", pending, 4'b0000);
    model_reset();
    step();
    rst = 0;
    chk("post_rst_ready", start_ready, 1'b1);
    ack(1, 0);
    step();

    // random rounds
    for (int r = 0; r < 40; r++) begin
      int n;
      quiet();
      start(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      n = 0;
      while ((m_active || m_done) && n < 300) begin
        b_ready = ($urandom_range(0, 9) < 7);
        ack_valid = 0; ack_data = 0;
        if (m_pend != '0 && $urandom_range(0, 2) == 0) begin
          int c;
          c = $urandom_range(0, 3);
          while (!m_pend[c]) c = (c + 1) % 4;
          ack_valid = 1; ack_id = 2'(c); ack_data = 1'($urandom_range(0, 1));
        end else if ($urandom_range(0, 9) == 0) begin
          ack_valid = 1; ack_id = 2'($urandom_range(0, 3)); ack_data = 1'($urandom_range(0, 1));
        end
        step();
        n++;
      end
      if (m_active || m_done) chk("round_timeout", 1, 0);
      quiet();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
